// File: rtl/touch_i2c_target.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : touch_i2c_target                                              |
// | Brief  : I2C target emulating a capacitive touch controller. 16-bit    |
// |          register pointer with auto-increment, product-ID / status /   |
// |          coordinate registers, touch injection and INT pulse.          |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module touch_i2c_target #(
    parameter logic [6:0]  SLAVE_ADDR    = 7'h14,
    parameter logic [15:0] REG_BASE      = 16'h8140,
    parameter int          REG_WIN       = 32,
    parameter int          INT_PULSE_CYC = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic        touch_req,
    input  logic [15:0] touch_x,
    input  logic [15:0] touch_y,
    output logic        touch_drop,
    output logic        int_n
);

    localparam int c_aw = $clog2(REG_WIN);
    localparam int c_cw = $clog2(INT_PULSE_CYC + 1);

    localparam logic [c_aw-1:0] c_off_status = c_aw'(14);
    localparam logic [c_aw-1:0] c_off_x_lo   = c_aw'(16);
    localparam logic [c_aw-1:0] c_off_x_hi   = c_aw'(17);
    localparam logic [c_aw-1:0] c_off_y_lo   = c_aw'(18);
    localparam logic [c_aw-1:0] c_off_y_hi   = c_aw'(19);
    localparam logic [c_cw-1:0] c_int_load   = c_cw'(INT_PULSE_CYC - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REGH      = 4'd3,
        ST_REGH_ACK  = 4'd4,
        ST_REGL      = 4'd5,
        ST_REGL_ACK  = 4'd6,
        ST_WDATA     = 4'd7,
        ST_WDATA_ACK = 4'd8,
        ST_RDATA     = 4'd9,
        ST_RDATA_ACK = 4'd10,
        ST_WAIT_P    = 4'd11
    } state_t;

    // Bus synchronizers and previous-sample registers for edge detection
    logic [1:0]      r_scl_sync;
    logic [1:0]      r_sda_sync;
    logic            r_scl_d;
    logic            r_sda_d;

    // Protocol engine state
    state_t          r_state;
    logic [3:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [6:0]      r_tx;
    logic [15:0]     r_ptr;
    logic            r_rw;
    logic            r_mack;
    logic            r_sda_oe;

    // Register file and touch/interrupt state
    logic [7:0]      r_regs [REG_WIN];
    logic            r_drop;
    logic            r_int_n;
    logic [c_cw-1:0] r_int_cnt;

    logic            w_scl_s;
    logic            w_sda_s;
    logic            w_scl_rise;
    logic            w_scl_fall;
    logic            w_start;
    logic            w_stop;
    logic [15:0]     w_off;
    logic            w_mapped;
    logic [c_aw-1:0] w_idx;
    logic [7:0]      w_rd_data;
    logic            w_wr_en;
    logic            w_touch_accept;

    // ID bytes and coordinate registers cannot be written from the bus
    function automatic logic is_ro(input logic [c_aw-1:0] idx);
        return (idx < c_aw'(4)) || ((idx >= c_off_x_lo) && (idx <= c_off_y_hi));
    endfunction

    assign w_scl_s    = r_scl_sync[1];
    assign w_sda_s    = r_sda_sync[1];
    assign w_scl_rise = w_scl_s & ~r_scl_d;
    assign w_scl_fall = ~w_scl_s & r_scl_d;
    assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

    assign w_off      = r_ptr - REG_BASE;
    assign w_mapped   = ({1'b0, w_off} < 17'(REG_WIN));
    assign w_idx      = w_off[c_aw-1:0];
    assign w_rd_data  = w_mapped ? r_regs[w_idx] : 8'h00;

    // Data byte commits on the 9th SCL rise of a write byte
    assign w_wr_en    = (r_state == ST_WDATA_ACK) && w_scl_rise && (r_bit_cnt == 4'd8)
                        && w_mapped && !is_ro(w_idx);

    assign w_touch_accept = touch_req & ~r_regs[c_off_status][7];

    assign sda_oe     = r_sda_oe;
    assign touch_drop = r_drop;
    assign int_n      = r_int_n;

    // Two-flop synchronizers on SCL/SDA plus one delayed copy for edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    // I2C protocol FSM: shifts on SCL rise, changes SDA drive only on SCL fall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_tx      <= 7'h00;
            r_ptr     <= 16'h0000;
            r_rw      <= 1'b0;
            r_mack    <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else if (w_start) begin
            r_state   <= ST_ADDR;
            r_bit_cnt <= 4'd0;
            r_sda_oe  <= 1'b0;
        end else if (w_stop) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_sda_oe  <= 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_REGH, ST_REGL, ST_WDATA: begin
                    if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                        r_shift   <= {r_shift[6:0], w_sda_s};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        r_sda_oe <= 1'b1;
                        case (r_state)
                            ST_ADDR: begin
                                if (r_shift[7:1] == SLAVE_ADDR) begin
                                    r_rw    <= r_shift[0];
                                    r_state <= ST_ADDR_ACK;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= ST_WAIT_P;
                                end
                            end
                            ST_REGH: begin
                                r_ptr[15:8] <= r_shift;
                                r_state     <= ST_REGH_ACK;
                            end
                            ST_REGL: begin
                                r_ptr[7:0] <= r_shift;
                                r_state    <= ST_REGL_ACK;
                            end
                            default: r_state <= ST_WDATA_ACK;
                        endcase
                    end
                end
                ST_ADDR_ACK, ST_REGH_ACK, ST_REGL_ACK, ST_WDATA_ACK: begin
                    if (w_scl_rise) begin
                        r_bit_cnt <= 4'd9;
                        if ((r_state == ST_WDATA_ACK) && (r_bit_cnt == 4'd8))
                            r_ptr <= r_ptr + 16'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd9)) begin
                        r_bit_cnt <= 4'd0;
                        r_sda_oe  <= 1'b0;
                        case (r_state)
                            ST_ADDR_ACK: begin
                                if (r_rw) begin
                                    // First read byte goes out right as the ACK is released
                                    r_tx     <= w_rd_data[6:0];
                                    r_sda_oe <= ~w_rd_data[7];
                                    r_ptr    <= r_ptr + 16'd1;
                                    r_state  <= ST_RDATA;
                                end else begin
                                    r_state <= ST_REGH;
                                end
                            end
                            ST_REGH_ACK: r_state <= ST_REGL;
                            default:     r_state <= ST_WDATA;
                        endcase
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        r_sda_oe <= 1'b0;
                        r_state  <= ST_RDATA_ACK;
                    end else if (w_scl_fall && (r_bit_cnt != 4'd0)) begin
                        r_tx     <= {r_tx[5:0], 1'b0};
                        r_sda_oe <= ~r_tx[6];
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        r_mack    <= w_sda_s;
                        r_bit_cnt <= 4'd9;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd9)) begin
                        r_bit_cnt <= 4'd0;
                        if (!r_mack) begin
                            r_tx     <= w_rd_data[6:0];
                            r_sda_oe <= ~w_rd_data[7];
                            r_ptr    <= r_ptr + 16'd1;
                            r_state  <= ST_RDATA;
                        end else begin
                            r_state <= ST_WAIT_P;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file: bus writes, touch injection (wins over a same-cycle status write)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_WIN; i++)
                r_regs[i] <= 8'h00;
            r_regs[0] <= 8'h39;
            r_regs[1] <= 8'h31;
            r_regs[2] <= 8'h34;
            r_regs[3] <= 8'h37;
        end else begin
            if (w_wr_en && !(w_touch_accept && (w_idx == c_off_status)))
                r_regs[w_idx] <= r_shift;
            if (w_touch_accept) begin
                r_regs[c_off_x_lo]   <= touch_x[7:0];
                r_regs[c_off_x_hi]   <= touch_x[15:8];
                r_regs[c_off_y_lo]   <= touch_y[7:0];
                r_regs[c_off_y_hi]   <= touch_y[15:8];
                r_regs[c_off_status] <= 8'h81;
            end
        end
    end

    // Drop pulse and INT low-pulse timer (restarted by every accepted touch)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop    <= 1'b0;
            r_int_n   <= 1'b1;
            r_int_cnt <= '0;
        end else begin
            r_drop <= touch_req & r_regs[c_off_status][7];
            if (w_touch_accept) begin
                r_int_n   <= 1'b0;
                r_int_cnt <= c_int_load;
            end else if (!r_int_n) begin
                if (r_int_cnt == '0)
                    r_int_n <= 1'b1;
                else
                    r_int_cnt <= r_int_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_touch_i2c_target.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module : tb_touch_i2c_target                                           |
// | Brief  : Directed self-checking bench for touch_i2c_target, driving    |
// |          the bus as a bit-banged I2C master.                           |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_touch_i2c_target;

    localparam int c_q = 10;   // clk cycles per SCL quarter phase

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        touch_req = 1'b0;
    logic [15:0] touch_x = 16'h0;
    logic [15:0] touch_y = 16'h0;
    logic        sda_oe;
    logic        touch_drop;
    logic        int_n;
    logic        sda_bus;

    int          n_tests = 0;
    int          n_fail = 0;
    int          nacks = 0;
    int          oe_cnt = 0;
    logic [7:0]  rdbuf [8];

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    // Counts every cycle the target pulls SDA low
    always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

    touch_i2c_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .touch_req (touch_req),
        .touch_x   (touch_x),
        .touch_y   (touch_y),
        .touch_drop(touch_drop),
        .int_n     (int_n)
    );

    task automatic hq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hq(c_q);
        scl = 1'b1;   hq(c_q);
        m_sda = 1'b0; hq(c_q);
        scl = 1'b0;   hq(c_q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hq(c_q);
        scl = 1'b1;   hq(c_q);
        m_sda = 1'b1; hq(c_q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; hq(c_q);
            scl = 1'b1;   hq(2 * c_q);
            scl = 1'b0;   hq(c_q);
        end
        m_sda = 1'b1; hq(c_q);
        scl = 1'b1;   hq(c_q);
        ack = sda_bus; hq(c_q);
        scl = 1'b0;   hq(c_q);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            hq(c_q);
            scl = 1'b1; hq(c_q);
            b[i] = sda_bus; hq(c_q);
            scl = 1'b0; hq(c_q);
        end
        m_sda = nack; hq(c_q);
        scl = 1'b1;   hq(2 * c_q);
        scl = 1'b0;   hq(c_q);
    endtask

    task automatic xfer_write(input logic [15:0] addr, input logic [7:0] data);
        logic a;
        i2c_start();
        wbyte(8'h28, a);       nacks += int'(a);
        wbyte(addr[15:8], a);  nacks += int'(a);
        wbyte(addr[7:0], a);   nacks += int'(a);
        wbyte(data, a);        nacks += int'(a);
        i2c_stop();
    endtask

    // Random read: leaves the bus after the final NACK without a STOP
    task automatic xfer_read(input logic [15:0] addr, input int n);
        logic a;
        logic [7:0] d;
        i2c_start();
        wbyte(8'h28, a);       nacks += int'(a);
        wbyte(addr[15:8], a);  nacks += int'(a);
        wbyte(addr[7:0], a);   nacks += int'(a);
        i2c_start();
        wbyte(8'h29, a);       nacks += int'(a);
        for (int i = 0; i < n; i++) begin
            rbyte(i == n - 1, d);
            rdbuf[i] = d;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hq(3);
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        n_tests++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL reset_int_n got %b want 1", int_n); end
        n_tests++; if (touch_drop !== 1'b0) begin n_fail++; $display("FAIL reset_touch_drop got %b want 0", touch_drop); end
        rst_n = 1'b1; hq(5);
    endtask

    task automatic test_write_read();
        nacks = 0;
        xfer_write(16'h815F, 8'hA5);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL wr_scratch_acks got %0d nacks want 0", nacks); end
        nacks = 0;
        xfer_read(16'h815F, 1); i2c_stop();
        n_tests++; if (rdbuf[0] !== 8'hA5) begin n_fail++; $display("FAIL rd_scratch got %h want a5", rdbuf[0]); end
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rd_scratch_acks got %0d nacks want 0", nacks); end
        nacks = 0;
        xfer_write(16'h8160, 8'h5A);
        xfer_read(16'h8160, 1); i2c_stop();
        n_tests++; if (rdbuf[0] !== 8'h00) begin n_fail++; $display("FAIL rd_unmapped got %h want 00", rdbuf[0]); end
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL unmapped_acks got %0d nacks want 0", nacks); end
    endtask

    task automatic test_product_id();
        logic [7:0] exp [4];
        exp[0] = 8'h39; exp[1] = 8'h31; exp[2] = 8'h34; exp[3] = 8'h37;
        nacks = 0;
        xfer_read(16'h8140, 4);
        hq(4);
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL nack_release got %b want 0", sda_oe); end
        i2c_stop();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rdbuf[i] !== exp[i]) begin n_fail++; $display("FAIL id_byte%0d got %h want %h", i, rdbuf[i], exp[i]); end
        end
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL id_acks got %0d nacks want 0", nacks); end
        xfer_write(16'h8140, 8'h00);
        xfer_read(16'h8140, 1); i2c_stop();
        n_tests++; if (rdbuf[0] !== 8'h39) begin n_fail++; $display("FAIL id_readonly got %h want 39", rdbuf[0]); end
    endtask

    task automatic test_bad_addr();
        logic a0, a1;
        int snap;
        snap = oe_cnt;
        i2c_start();
        wbyte(8'h2A, a0);
        wbyte(8'h81, a1);
        i2c_stop();
        n_tests++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL badaddr_ack got %b want 1", a0); end
        n_tests++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL badaddr_byte2_ack got %b want 1", a1); end
        n_tests++; if (oe_cnt !== snap) begin n_fail++; $display("FAIL badaddr_oe got %0d cycles want 0", oe_cnt - snap); end
    endtask

    task automatic test_touch();
        int low;
        touch_x = 16'h0123; touch_y = 16'h01E0; touch_req = 1'b1;
        @(negedge clk); touch_req = 1'b0;
        n_tests++; if (touch_drop !== 1'b0) begin n_fail++; $display("FAIL touch_nodrop got %b want 0", touch_drop); end
        low = (int_n === 1'b0) ? 1 : 0;
        while ((int_n === 1'b0) && (low < 1000)) begin
            @(negedge clk);
            if (int_n === 1'b0) low++;
        end
        n_tests++; if (low !== 100) begin n_fail++; $display("FAIL int_pulse_len got %0d want 100", low); end
        xfer_read(16'h814E, 6); i2c_stop();
        n_tests++; if (rdbuf[0] !== 8'h81) begin n_fail++; $display("FAIL touch_status got %h want 81", rdbuf[0]); end
        n_tests++; if (rdbuf[2] !== 8'h23) begin n_fail++; $display("FAIL touch_xlo got %h want 23", rdbuf[2]); end
        n_tests++; if (rdbuf[3] !== 8'h01) begin n_fail++; $display("FAIL touch_xhi got %h want 01", rdbuf[3]); end
        n_tests++; if (rdbuf[4] !== 8'hE0) begin n_fail++; $display("FAIL touch_ylo got %h want e0", rdbuf[4]); end
        n_tests++; if (rdbuf[5] !== 8'h01) begin n_fail++; $display("FAIL touch_yhi got %h want 01", rdbuf[5]); end
    endtask

    task automatic test_drop();
        touch_x = 16'h0456; touch_y = 16'h0789; touch_req = 1'b1;
        @(negedge clk); touch_req = 1'b0;
        n_tests++; if (touch_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got %b want 1", touch_drop); end
        n_tests++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL drop_int_n got %b want 1", int_n); end
        @(negedge clk);
        n_tests++; if (touch_drop !== 1'b0) begin n_fail++; $display("FAIL drop_width got %b want 0", touch_drop); end
        xfer_read(16'h8150, 1); i2c_stop();
        n_tests++; if (rdbuf[0] !== 8'h23) begin n_fail++; $display("FAIL drop_xlo_kept got %h want 23", rdbuf[0]); end
        xfer_write(16'h814E, 8'h00);
        touch_req = 1'b1;
        @(negedge clk); touch_req = 1'b0;
        n_tests++; if (touch_drop !== 1'b0) begin n_fail++; $display("FAIL retry_nodrop got %b want 0", touch_drop); end
        n_tests++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL retry_int_n got %b want 0", int_n); end
        xfer_read(16'h8150, 2); i2c_stop();
        n_tests++; if (rdbuf[0] !== 8'h56) begin n_fail++; $display("FAIL retry_xlo got %h want 56", rdbuf[0]); end
        n_tests++; if (rdbuf[1] !== 8'h04) begin n_fail++; $display("FAIL retry_xhi got %h want 04", rdbuf[1]); end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        xfer_write(16'h8145, 8'h3C);
        i2c_start();
        wbyte(8'h28, a); wbyte(8'h81, a); wbyte(8'h45, a);
        i2c_start();
        wbyte(8'h29, a);
        hq(2);
        n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midread_driving got %b want 1", sda_oe); end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midread_reset_oe got %b want 0", sda_oe); end
        rst_n = 1'b1; hq(5);
        i2c_stop();
        nacks = 0;
        xfer_read(16'h8145, 1); i2c_stop();
        n_tests++; if (rdbuf[0] !== 8'h00) begin n_fail++; $display("FAIL midread_scratch got %h want 00", rdbuf[0]); end
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL midread_acks got %0d nacks want 0", nacks); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_product_id();
        test_bad_addr();
        test_touch();
        test_drop();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
